// File: rtl/req_cmd_assembler.sv
// Deserialises a host byte stream (header + key/text/dest addresses, MSB first) into one request
// and presents it to the request queue with valid/ready, steered to the AES or SHA ready by opcode.
module req_cmd_assembler #(
    parameter int          ADDRW   = 24,
    parameter int          OPCODEW = 2,
    parameter logic [3:0]  MAGIC   = 4'hA
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic [OPCODEW-1:0] opcode,
    output logic [ADDRW-1:0]   key_addr,
    output logic [ADDRW-1:0]   text_addr,
    output logic [ADDRW-1:0]   dest_addr,
    output logic               valid_in,
    input  logic               ready_in_aes,
    input  logic               ready_in_sha,
    output logic               hdr_err,
    output logic [7:0]         req_count
);

    // state   | meaning
    // S_HDR   | waiting for header byte
    // S_KEY   | collecting key address bytes
    // S_TEXT  | collecting text address bytes
    // S_DEST  | collecting destination address bytes
    // S_ISSUE | request presented, waiting for the selected queue ready

    localparam int NB   = ADDRW / 8;
    localparam int CNTW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NB - 1);

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_KEY   = 3'd1,
        S_TEXT  = 3'd2,
        S_DEST  = 3'd3,
        S_ISSUE = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CNTW-1:0] cnt;
    logic            accept;
    logic            hdr_ok;
    logic            last_byte;
    logic            rdy;
    logic            xfer;

    assign accept    = byte_valid && byte_ready;
    // Bits between the opcode and the magic nibble must be zero.
    assign hdr_ok    = (byte_in[7:4] == MAGIC) && ((byte_in[3:0] >> OPCODEW) == 4'd0);
    assign last_byte = (cnt == CNT_LAST);
    assign rdy       = opcode[OPCODEW-1] ? ready_in_sha : ready_in_aes;
    assign xfer      = valid_in && rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HDR:   if (accept && hdr_ok)    state_nxt = S_KEY;
            S_KEY:   if (accept && last_byte) state_nxt = S_TEXT;
            S_TEXT:  if (accept && last_byte) state_nxt = S_DEST;
            S_DEST:  if (accept && last_byte) state_nxt = S_ISSUE;
            S_ISSUE: if (xfer)                state_nxt = S_HDR;
            default:                          state_nxt = S_HDR;
        endcase
    end

    always_comb begin
        byte_ready = (state != S_ISSUE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            opcode    <= '0;
            key_addr  <= '0;
            text_addr <= '0;
            dest_addr <= '0;
            valid_in  <= 1'b0;
            hdr_err   <= 1'b0;
            req_count <= 8'd0;
        end else begin
            hdr_err <= 1'b0;
            case (state)
                S_HDR: begin
                    if (accept) begin
                        if (hdr_ok) begin
                            opcode <= byte_in[OPCODEW-1:0];
                            cnt    <= '0;
                        end else begin
                            hdr_err <= 1'b1;
                        end
                    end
                end
                S_KEY: begin
                    if (accept) begin
                        key_addr <= (key_addr << 8) | ADDRW'(byte_in);
                        cnt      <= last_byte ? '0 : cnt + CNTW'(1);
                    end
                end
                S_TEXT: begin
                    if (accept) begin
                        text_addr <= (text_addr << 8) | ADDRW'(byte_in);
                        cnt       <= last_byte ? '0 : cnt + CNTW'(1);
                    end
                end
                S_DEST: begin
                    if (accept) begin
                        dest_addr <= (dest_addr << 8) | ADDRW'(byte_in);
                        cnt       <= last_byte ? '0 : cnt + CNTW'(1);
                        if (last_byte) valid_in <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (xfer) begin
                        valid_in  <= 1'b0;
                        req_count <= req_count + 8'd1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule
